hier_node_rr_agg: RTL and testbench

Parametrised hierarchy node that instantiates NUM_CHILDREN leaf token generators and merges their outputs onto one valid/ready stream. Each child lane has a registered one-entry holding slot, and a round-robin arbiter selects among the full slots. It is the next-generation form of the fixed five-child hierarchy node: the child count is a parameter, and every child now has real traffic. It sits at any level of the generated hierarchy, with its output feeding the parent node's child lane.

---
 rtl/hier_node_pkg.sv | 23 ++
 rtl/hier_leaf_tick.sv | 61 ++++++
 rtl/hier_node_rr_agg.sv | 154 +++++++++++++++
 tb/tb_hier_node_rr_agg.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/hier_node_pkg.sv
// Shared types and constants for the round-robin hierarchy node and its leaves.
package hier_node_pkg;

    localparam int unsigned OVF_CNT_W  = 16;
    localparam int unsigned TOK_DATA_W = 32;
    localparam int unsigned TOK_ID_W   = 5;

    // Sized for the widest supported node; each instance uses the low bits it needs.
    typedef struct packed {
        logic [TOK_DATA_W-1:0] data;
        logic [TOK_ID_W-1:0]   id;
    } token_t;

    typedef enum logic [0:0] {
        StEmpty,
        StHeld
    } out_state_e;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 32'd2) ? unsigned'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/hier_leaf_tick.sv
// Leaf token generator: period counter, sequence counter and a one-entry holding slot.
module hier_leaf_tick #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned PERIOD_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    input  logic                grant,
    output logic                full,
    output logic [DATA_W-1:0]   data,
    output logic                drop,
    output logic                ovf
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]   seq_q, seq_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                full_q, full_d;
    logic                ovf_q, ovf_d;
    logic                tick;
    logic                load;

    always_comb begin
        tick   = en && (cnt_q == period);
        // A slot granted this cycle is free to take the new token.
        load   = tick && (!full_q || grant);
        drop   = tick && full_q && !grant;

        cnt_d  = cnt_q;
        if (en) begin
            cnt_d = tick ? '0 : cnt_q + PERIOD_W'(1);
        end
        seq_d  = tick ? seq_q + DATA_W'(1) : seq_q;
        data_d = load ? seq_q : data_q;
        full_d = load ? 1'b1 : (grant ? 1'b0 : full_q);
        ovf_d  = ovf_q | drop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            seq_q  <= '0;
            data_q <= '0;
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            seq_q  <= seq_d;
            data_q <= data_d;
            full_q <= full_d;
            ovf_q  <= ovf_d;
        end
    end

    assign full = full_q;
    assign data = data_q;
    assign ovf  = ovf_q;

endmodule

// File: rtl/hier_node_rr_agg.sv
// Hierarchy node merging NUM_CHILDREN leaf streams through a round-robin arbiter.
// Optional drop counter on ovf_cnt is built when HIER_NODE_OVF_CNT_EN is defined.
module hier_node_rr_agg
    import hier_node_pkg::*;
#(
    parameter int unsigned NUM_CHILDREN = 5,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned PERIOD_W     = 4,
    localparam int unsigned ID_W        = id_width(NUM_CHILDREN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [PERIOD_W-1:0]     period,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [ID_W-1:0]         out_id,
    output logic [NUM_CHILDREN-1:0] ovf_flag,
    output logic [OVF_CNT_W-1:0]    ovf_cnt
);

    logic [NUM_CHILDREN-1:0] full;
    logic [NUM_CHILDREN-1:0] grant;
    logic [NUM_CHILDREN-1:0] drop;
    logic [DATA_W-1:0]       slot_data [NUM_CHILDREN];

    out_state_e              state_q, state_d;
    token_t                  tok_q, tok_d;
    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic [ID_W-1:0]         gnt_idx;
    logic                    gnt_any;
    logic                    out_free;

    for (genvar k = 0; k < NUM_CHILDREN; k++) begin : g_leaf
        hier_leaf_tick #(
            .DATA_W   (DATA_W),
            .PERIOD_W (PERIOD_W)
        ) u_leaf (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .period (period),
            .grant  (grant[k]),
            .full   (full[k]),
            .data   (slot_data[k]),
            .drop   (drop[k]),
            .ovf    (ovf_flag[k])
        );
    end

    assign out_free = (state_q == StEmpty) || out_ready;

    // First full slot at or above ptr, wrapping at the last child.
    always_comb begin : arb
        int j;
        j       = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        grant   = '0;
        if (out_free) begin
            for (int i = 0; i < int'(NUM_CHILDREN); i++) begin
                j = int'(ptr_q) + i;
                if (j >= int'(NUM_CHILDREN)) begin
                    j = j - int'(NUM_CHILDREN);
                end
                if (!gnt_any && full[ID_W'(j)]) begin
                    gnt_any = 1'b1;
                    gnt_idx = ID_W'(j);
                end
            end
        end
        if (gnt_any) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        tok_d = tok_q;
        if (gnt_any) begin
            ptr_d      = (gnt_idx == ID_W'(NUM_CHILDREN - 1)) ? '0 : gnt_idx + ID_W'(1);
            tok_d.data = TOK_DATA_W'(slot_data[gnt_idx]);
            tok_d.id   = TOK_ID_W'(gnt_idx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (gnt_any) state_d = StHeld;
            StHeld:  if (out_ready && !gnt_any) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    always_comb begin
        out_valid = (state_q == StHeld);
        out_data  = tok_q.data[DATA_W-1:0];
        out_id    = tok_q.id[ID_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            tok_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            tok_q <= tok_d;
        end
    end

    // Upper token bits are always zero for narrower instances.
    logic unused_tok_bits;
    assign unused_tok_bits = ^tok_q;

`ifdef HIER_NODE_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [OVF_CNT_W-1:0] drop_sum;
    logic [OVF_CNT_W:0]   ovf_sum;

    always_comb begin
        drop_sum = '0;
        for (int k = 0; k < int'(NUM_CHILDREN); k++) begin
            drop_sum = drop_sum + OVF_CNT_W'(drop[k]);
        end
        ovf_sum   = {1'b0, ovf_cnt_q} + {1'b0, drop_sum};
        ovf_cnt_d = ovf_sum[OVF_CNT_W] ? '1 : ovf_sum[OVF_CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = ^drop;
    assign ovf_cnt     = '0;
`endif

endmodule

// File: tb/tb_hier_node_rr_agg.sv
// Randomized scoreboard bench for hier_node_rr_agg against a transaction-level lane model.
module tb_hier_node_rr_agg;

    localparam int N  = 5;
    localparam int DW = 8;
    localparam int PW = 4;
    localparam int IW = 3;

    logic          clk;
    logic          rst;
    logic          en;
    logic [PW-1:0] period;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_id;
    logic [N-1:0]  ovf_flag;
    logic [15:0]   ovf_cnt;

    hier_node_rr_agg #(
        .NUM_CHILDREN (N),
        .DATA_W       (DW),
        .PERIOD_W     (PW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .period    (period),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .ovf_flag  (ovf_flag),
        .ovf_cnt   (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int data;
        int id;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Lane model: ticks counted arithmetically, slots as "token pending" flags.
    int   m_cnt  [N];
    int   m_seq  [N];
    bit   m_full [N];
    int   m_data [N];
    bit   m_ovf  [N];
    int   m_ptr;
    bit   m_ov;
    int   m_total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_cnt[k]  = 0;
            m_seq[k]  = 0;
            m_full[k] = 0;
            m_data[k] = 0;
            m_ovf[k]  = 0;
        end
        m_ptr   = 0;
        m_ov    = 0;
        m_total = 0;
        q.delete();
    endtask

    task automatic model_step();
        bit free;
        int g;
        int drops;
        free = !m_ov || out_ready;
        g    = -1;
        if (free) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (g < 0 && m_full[k]) g = k;
            end
            if (g >= 0) begin
                q.push_back('{data: m_data[g], id: g});
                m_ov      = 1;
                m_ptr     = (g + 1) % N;
                m_full[g] = 0;
            end else begin
                m_ov = 0;
            end
        end
        drops = 0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                if (m_cnt[k] == int'(period)) begin
                    m_cnt[k] = 0;
                    if (m_full[k]) begin
                        m_ovf[k] = 1;
                        drops++;
                    end else begin
                        m_full[k] = 1;
                        m_data[k] = m_seq[k];
                    end
                    m_seq[k] = (m_seq[k] + 1) % (1 << DW);
                end else begin
                    m_cnt[k] = (m_cnt[k] + 1) % (1 << PW);
                end
            end
        end
        m_total = (m_total + drops > 65535) ? 65535 : m_total + drops;
    endtask

    task automatic cycle(input bit nen, input int nper, input bit nready);
        @(posedge clk);
        if (!rst) model_step();
        #1;
        en        = nen;
        period    = PW'(nper);
        out_ready = nready;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: checks every observable against the model each cycle, pops on transfers.
    initial begin
        bit            pv;
        bit            pr;
        logic [DW-1:0] pd;
        logic [IW-1:0] pi;
        logic [N-1:0]  exp_flags;
        exp_t          e;
        pv = 0;
        pr = 0;
        pd = '0;
        pi = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) exp_flags[k] = m_ovf[k];
            check("out_valid", 32'(out_valid), 32'(m_ov));
            check("ovf_flag", 32'(ovf_flag), 32'(exp_flags));
`ifdef HIER_NODE_OVF_CNT_EN
            check("ovf_cnt", 32'(ovf_cnt), 32'(m_total));
`else
            check("ovf_cnt", 32'(ovf_cnt), 32'd0);
`endif
            if (!rst && pv && !pr) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(pd));
                check("hold_id", 32'(out_id), 32'(pi));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_token", 32'(out_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("tok_data", 32'(out_data), 32'(e.data));
                    check("tok_id", 32'(out_id), 32'(e.id));
                end
            end
            pv = out_valid && !rst;
            pr = out_ready;
            pd = out_data;
            pi = out_id;
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        period    = 4'd3;
        out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b1;

        repeat (40) cycle(1, 3, 1);

        // Long stall: every lane ends up dropping.
        repeat (20) cycle(1, 3, 0);
        @(negedge clk);
        check("bp_ovf_all", 32'(ovf_flag), 32'h1f);
        repeat (30) cycle(1, 3, 1);

        // Reset while a token is held under backpressure.
        repeat (6) cycle(1, 3, 0);
        @(negedge clk);
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        do_reset();
        out_ready = 1'b1;
        repeat (30) cycle(1, 3, 1);

        // Every enabled cycle ticks; long enough for the sequence to wrap.
        do_reset();
        repeat (400) cycle(1, 0, 1);

        for (int c = 0; c < 3000; c++) begin
            int  np;
            bit  ne;
            bit  nr;
            np = (c % 50 == 0) ? int'($urandom_range(0, 15)) : int'(period);
            ne = ($urandom_range(0, 9) != 0);
            nr = ((c / 64) % 4 == 3) ? ($urandom_range(0, 4) == 0)
                                     : ($urandom_range(0, 3) != 0);
            if (c == 1500) do_reset();
            cycle(ne, np, nr);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
